// File: rtl/vrased_reset_ctrl_pkg.sv
// Shared definitions for the VRASED reset controller: FSM encodings, the
// monitors' reset-handler address and the kill_req bit assignments.
package vrased_defs;

   localparam logic [1:0] ST_BOOT    = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_ASSERT  = 2'd2;
   localparam logic [1:0] ST_RECOVER = 2'd3;

   localparam logic [15:0] RESET_HANDLER_ADDR = 16'h0000;

   // kill_req bit positions, one per hw-mod monitor
   localparam int MON_DMA_X_STACK = 0;
   localparam int MON_X_STACK     = 1;
   localparam int MON_AC          = 2;
   localparam int MON_ATOMICITY   = 3;
   localparam int MON_COUNT       = 4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/vrased_sat_cnt.sv
// 8-bit saturating event counter; holds at 8'hFF instead of wrapping.
module vrased_sat_cnt
   import vrased_defs::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   output logic [7:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= 8'd0;
      end else if (en) begin
         count <= sat_inc8(count);
      end
   end

endmodule

// File: rtl/vrased_reset_ctrl.sv
// Stretches monitor kill requests into a minimum-width core reset and keeps
// a sticky cause vector plus a saturating violation count.
//
// state   | meaning
// BOOT    | power-on reset stretch, no cause/count bookkeeping
// IDLE    | core running, waiting for a kill request
// ASSERT  | core held in reset for RST_CYCLES cycles, causes accumulate
// RECOVER | reset released, kill_req masked until monitors drop it
module vrased_reset_ctrl
   import vrased_defs::*;
#(
   parameter int          N_MON         = MON_COUNT,
   parameter logic [15:0] RST_CYCLES    = 16'd8,
   parameter logic [15:0] RECOVER_MAX   = 16'd64,
   parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_ADDR
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_MON-1:0] kill_req,
   input  logic [15:0]      pc,
   input  logic             clr_cause,
   output logic             sys_rst,
   output logic [N_MON-1:0] cause,
   output logic [7:0]       viol_cnt,
   output logic             busy
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [15:0]      cnt;
   logic [15:0]      cnt_nxt;
   logic [N_MON-1:0] cause_nxt;
   logic             viol_inc;
   logic             any_kill;

   assign any_kill = |kill_req;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cause_nxt = cause;
      viol_inc  = 1'b0;
      case (state)
         ST_BOOT: begin
            if (cnt == RST_CYCLES - 16'd1) begin
               state_nxt = ST_RECOVER;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         ST_IDLE: begin
            // a new request in the same cycle as the clear wins
            cause_nxt = clr_cause ? kill_req : (cause | kill_req);
            if (any_kill) begin
               state_nxt = ST_ASSERT;
               cnt_nxt   = 16'd0;
               viol_inc  = 1'b1;
            end
         end
         ST_ASSERT: begin
            cause_nxt = cause | kill_req;
            if (cnt == RST_CYCLES - 16'd1) begin
               state_nxt = ST_RECOVER;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            if (!any_kill) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = 16'd0;
            end else if (pc == RESET_HANDLER) begin
               // monitor is about to leave KILL; never time out on this cycle
               cnt_nxt = cnt + 16'd1;
            end else if (cnt >= RECOVER_MAX - 16'd1) begin
               state_nxt = ST_ASSERT;
               cnt_nxt   = 16'd0;
               viol_inc  = 1'b1;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_BOOT;
         cnt     <= 16'd0;
         cause   <= '0;
         sys_rst <= 1'b1;
         busy    <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         cause   <= cause_nxt;
         sys_rst <= (state_nxt == ST_BOOT) || (state_nxt == ST_ASSERT);
         busy    <= (state_nxt != ST_IDLE);
      end
   end

   vrased_sat_cnt u_viol_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (viol_inc),
      .count   (viol_cnt)
   );

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Self-checking bench for vrased_reset_ctrl: directed scenarios plus random
// kill/pc/clr traffic checked every cycle against a behavioural model.
module tb_vrased_reset_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  kill_req;
   logic [15:0] pc;
   logic        clr_cause;
   logic        sys_rst;
   logic [3:0]  cause;
   logic [7:0]  viol_cnt;
   logic        busy;

   int n_vec  = 0;
   int n_fail = 0;

   // model: cycles of reset still owed, recovery age, bookkeeping
   int         m_rst_left;
   bit         m_booting;
   bit         m_recovering;
   int         m_rec_age;
   logic [3:0] m_cause;
   int         m_viol;

   vrased_reset_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .kill_req  (kill_req),
      .pc        (pc),
      .clr_cause (clr_cause),
      .sys_rst   (sys_rst),
      .cause     (cause),
      .viol_cnt  (viol_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_rst_left   = 8;
      m_booting    = 1'b1;
      m_recovering = 1'b0;
      m_rec_age    = 0;
      m_cause      = 4'b0;
      m_viol       = 0;
   endfunction

   function automatic void model_step(input logic [3:0] k, input logic [15:0] p, input logic c);
      if (m_rst_left > 0) begin
         if (!m_booting) m_cause = m_cause | k;
         m_rst_left--;
         if (m_rst_left == 0) begin
            m_recovering = 1'b1;
            m_rec_age    = 0;
            m_booting    = 1'b0;
         end
      end else if (m_recovering) begin
         if (k == 4'b0) begin
            m_recovering = 1'b0;
         end else if (p == 16'h0000) begin
            m_rec_age++;
         end else if (m_rec_age >= 63) begin
            m_recovering = 1'b0;
            m_rst_left   = 8;
            if (m_viol < 255) m_viol++;
         end else begin
            m_rec_age++;
         end
      end else begin
         m_cause = c ? k : (m_cause | k);
         if (k != 4'b0) begin
            m_rst_left = 8;
            if (m_viol < 255) m_viol++;
         end
      end
   endfunction

   task automatic compare_all();
      check("sys_rst", 32'(sys_rst), 32'(m_rst_left > 0));
      check("busy", 32'(busy), 32'((m_rst_left > 0) || m_recovering));
      check("cause", 32'(cause), 32'(m_cause));
      check("viol_cnt", 32'(viol_cnt), 32'(m_viol));
   endtask

   task automatic cycle(input logic [3:0] k, input logic [15:0] p, input logic c);
      kill_req  = k;
      pc        = p;
      clr_cause = c;
      @(posedge clk);
      model_step(k, p, c);
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         cycle(4'b0, 16'h4400, 1'b0);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_cause"}, 32'(cause), 32'd0);
      check({tag, "_viol"}, 32'(viol_cnt), 32'd0);
   endtask

   initial begin
      int fall_at;
      int busy_at;
      int width;
      int low_run;
      int ph;
      int burst;
      logic [3:0]  bk;
      logic [3:0]  rk;
      logic [15:0] rp;

      reset_n   = 1'b0;
      kill_req  = 4'b0;
      pc        = 16'h4400;
      clr_cause = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("por");
      reset_n = 1'b1;

      // boot stretch: sys_rst drops after edge 8, busy after edge 9
      fall_at = 0;
      busy_at = 0;
      for (int i = 1; i <= 12; i++) begin
         cycle(4'b0, 16'h4400, 1'b0);
         if (!sys_rst && fall_at == 0) fall_at = i;
         if (!busy && busy_at == 0) busy_at = i;
      end
      check("boot_fall_edge", 32'(fall_at), 32'd8);
      check("boot_busy_edge", 32'(busy_at), 32'd9);
      check("boot_viol", 32'(viol_cnt), 32'd0);

      // single request, plus a second source raised while asserted
      width = 0;
      for (int i = 0; i < 15; i++) begin
         cycle((i == 0) ? 4'b0001 : ((i == 3) ? 4'b0100 : 4'b0000), 16'h4400, 1'b0);
         if (sys_rst) width++;
      end
      check("assert_width", 32'(width), 32'd8);
      check("assert_cause", 32'(cause), 32'h5);
      check("assert_viol", 32'(viol_cnt), 32'd1);

      // held request: 64 recover cycles, then a timeout re-assert
      low_run = 0;
      ph = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(4'b0001, 16'h4400, 1'b0);
         if (ph == 0 && sys_rst) ph = 1;
         else if (ph == 1 && !sys_rst) begin ph = 2; low_run = 1; end
         else if (ph == 2 && !sys_rst) low_run++;
         else if (ph == 2 && sys_rst) ph = 3;
      end
      check("recover_gap", 32'(low_run), 32'd64);
      check("timeout_viol", 32'(viol_cnt), 32'd3);
      wait_idle();

      // set beats clear in the same IDLE cycle
      cycle(4'b0010, 16'h4400, 1'b1);
      check("setclr_cause", 32'(cause), 32'h2);
      check("setclr_sys_rst", 32'(sys_rst), 32'd1);
      wait_idle();
      cycle(4'b0000, 16'h4400, 1'b1);
      check("clr_cause", 32'(cause), 32'h0);

      // random traffic with bursts long enough to hit the recover timeout
      burst = 0;
      bk = 4'b0;
      for (int i = 0; i < 2500; i++) begin
         if (burst == 0 && $urandom_range(9) == 0) begin
            burst = $urandom_range(90, 1);
            bk = 4'($urandom_range(15, 1));
         end
         rk = (burst > 0) ? bk : 4'b0;
         if (burst > 0) burst--;
         rp = ($urandom_range(15) == 0) ? 16'h0000 : 16'($urandom);
         cycle(rk, rp, 1'($urandom_range(7) == 0));
      end

      wait_idle();
      for (int i = 0; i < 300; i++) begin
         cycle(4'b0001, 16'h4400, 1'b0);
         wait_idle();
      end
      check("sat_viol", 32'(viol_cnt), 32'hFF);

      // async reset in the middle of an ASSERT window
      cycle(4'b0001, 16'h4400, 1'b0);
      cycle(4'b0000, 16'h4400, 1'b0);
      cycle(4'b0000, 16'h4400, 1'b0);
      #2 reset_n = 1'b0;
      #1 check_reset_values("async");
      model_reset();
      @(negedge clk);
      check_reset_values("async_hold");
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) cycle(4'b0000, 16'h4400, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
